// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single outstanding reads
// to instruction memory and queues returned words for the decoder.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       in32,
    output logic [ADDR_W-1:0] in32_pc,
    output logic              in32_valid,
    input  logic              dec_ready
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       word_q [DEPTH];
    logic [31:0]       word_d [DEPTH];
    logic [ADDR_W-1:0] wpc_q [DEPTH];
    logic [ADDR_W-1:0] wpc_d [DEPTH];

    logic          pop;
    logic          push;
    logic          space;
    logic          issue;
    logic [CW:0]   level;
    logic [CW-1:0] wr_idx;

    assign in32_valid = (count_q != '0);
    assign in32       = word_q[0];
    assign in32_pc    = wpc_q[0];
    assign imem_req   = issue;
    assign imem_addr  = pc_q;

    // Handshake qualifiers and the request-issue decision.
    always_comb begin
        pop   = in32_valid & dec_ready;
        push  = imem_ack & (state_q == S_WAIT) & ~redirect;
        level = (CW+1)'(count_q) + (CW+1)'(push) - (CW+1)'(pop);
        space = (level < DEPTH_L);
        issue = ~rst & ~redirect & space &
                ((state_q == S_RUN) |
                 ((state_q == S_WAIT) & imem_ack));
    end

    // Shift-style prefetch FIFO: entry 0 is always the head.
    always_comb begin
        word_d  = word_q;
        wpc_d   = wpc_q;
        wr_idx  = count_q - CW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
        if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                word_d[i] = word_q[i+1];
                wpc_d[i]  = wpc_q[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (wr_idx == CW'(i)) begin
                    word_d[i] = imem_rdata;
                    wpc_d[i]  = req_pc_q;
                end
            end
        end
        if (redirect) begin
            count_d = '0;
        end
    end

    // Fetch FSM next state and PC update; redirect outranks issue.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
            unique case (state_q)
                S_RUN:   state_d = S_RUN;
                S_WAIT:  state_d = imem_ack ? S_RUN : S_DRAIN;
                S_DRAIN: state_d = imem_ack ? S_RUN : S_DRAIN;
                default: state_d = S_RUN;
            endcase
        end else if (issue) begin
            pc_d     = pc_q + ADDR_W'(1);
            req_pc_d = pc_q;
            state_d  = S_WAIT;
        end else if (imem_ack && (state_q != S_RUN)) begin
            state_d = S_RUN;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                word_q[i] <= '0;
                wpc_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            word_q   <= word_d;
            wpc_q    <= wpc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model plus in-order scoreboard.
// Two instances cover a normal reset PC and the wrap-around case.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1;
    logic        rst1 = 1'b1;
    logic        sel = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        dec_ready = 1'b0;

    logic        req0, req1, val0, val1;
    logic [15:0] addr0, addr1, ipc0, ipc1;
    logic [31:0] in0, in1;

    logic        act_rst, act_req, act_val;
    logic [15:0] act_addr, act_pc;
    logic [31:0] act_in;

    int tests = 0;
    int fails = 0;
    int lat = 1;

    logic [47:0] q[$];
    logic [47:0] exp_e;
    bit          pend = 0;
    bit          disc = 0;
    bit          ack_disc = 0;
    int          cnt = 0;
    int          act_cnt;
    logic [15:0] paddr = '0;
    logic [15:0] ack_addr = '0;

    fetch_unit #(
        .ADDR_W(16), .RESET_PC(16'h0010), .DEPTH(2)
    ) dut0 (
        .clk(clk), .rst(rst0),
        .imem_req(req0), .imem_addr(addr0),
        .imem_ack(ack), .imem_rdata(rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .in32(in0), .in32_pc(ipc0), .in32_valid(val0),
        .dec_ready(dec_ready)
    );

    fetch_unit #(
        .ADDR_W(16), .RESET_PC(16'hFFFF), .DEPTH(2)
    ) dut1 (
        .clk(clk), .rst(rst1),
        .imem_req(req1), .imem_addr(addr1),
        .imem_ack(ack), .imem_rdata(rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .in32(in1), .in32_pc(ipc1), .in32_valid(val1),
        .dec_ready(dec_ready)
    );

    assign act_rst  = sel ? rst1 : rst0;
    assign act_req  = sel ? req1 : req0;
    assign act_val  = sel ? val1 : val0;
    assign act_addr = sel ? addr1 : addr0;
    assign act_pc   = sel ? ipc1 : ipc0;
    assign act_in   = sel ? in1 : in0;

    function automatic logic [31:0] wordof(logic [15:0] a);
        case (a)
            16'h0010: return 32'h0C030A00;
            16'h0011: return 32'h0C320000;
            16'h0012: return 32'hBD547E00;
            default:  return {a, ~a};
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model and scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ack = 1'b0;
            ack_disc = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    ack = 1'b1;
                    rdata = wordof(paddr);
                    ack_addr = paddr;
                    ack_disc = disc;
                    pend = 0;
                    disc = 0;
                end else begin
                    cnt--;
                end
            end
            @(negedge clk);
            act_cnt = sel ? int'(dut1.count_q) : int'(dut0.count_q);
            if (act_rst) begin
                q.delete();
                pend = 0;
                disc = 0;
            end else begin
                check("count_plus_outstanding",
                      64'((act_cnt + (pend ? 1 : 0)) <= 2), 64'd1);
                if (act_val && dec_ready) begin
                    check("sb_nonempty", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        exp_e = q.pop_front();
                        check("pop_word", 64'({act_in, act_pc}), 64'(exp_e));
                    end
                end
                if (ack && !ack_disc && !redirect)
                    q.push_back({rdata, ack_addr});
                if (redirect) begin
                    q.delete();
                    if (pend) disc = 1;
                end
                if (act_req) begin
                    pend = 1;
                    paddr = act_addr;
                    cnt = lat - 1;
                    disc = 0;
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        repeat (3) step();
        #2;
        check("rst_req", 64'(req0), 64'd0);
        check("rst_addr", 64'(addr0), 64'h0010);
        check("rst_in32", 64'(in0), 64'd0);
        check("rst_in32_pc", 64'(ipc0), 64'd0);
        check("rst_valid", 64'(val0), 64'd0);

        step(); rst0 = 0; dec_ready = 1; #2;
        check("first_req", 64'(req0), 64'd1);
        check("first_addr", 64'(addr0), 64'h0010);
        step(); #2;
        check("s1_addr", 64'({req0, addr0}), 64'h1_0011);
        check("s1_valid", 64'(val0), 64'd0);
        step(); #2;
        check("s2_head", 64'({val0, in0, ipc0}), {15'd0, 1'b1, 32'h0C030A00, 16'h0010});
        step(); #2;
        check("s3_head", 64'({val0, in0, ipc0}), {15'd0, 1'b1, 32'h0C320000, 16'h0011});
        step(); #2;
        check("s4_head", 64'({val0, in0, ipc0}), {15'd0, 1'b1, 32'hBD547E00, 16'h0012});

        step(); rst0 = 1; dec_ready = 0;
        step(); rst0 = 0; #2;
        check("bp_req0", 64'({req0, addr0}), 64'h1_0010);
        step(); #2;
        check("bp_req1", 64'({req0, addr0}), 64'h1_0011);
        step(); #2;
        check("bp_full_req", 64'(req0), 64'd0);
        check("bp_head", 64'({val0, in0}), {31'd0, 1'b1, 32'h0C030A00});
        for (int i = 0; i < 3; i++) begin
            step(); #2;
            check("bp_hold_req", 64'(req0), 64'd0);
            check("bp_hold_head", 64'({in0, ipc0}), {16'd0, 32'h0C030A00, 16'h0010});
        end
        step(); dec_ready = 1; #2;
        check("bp_resume_req", 64'({req0, addr0}), 64'h1_0012);
        step(); #2;
        check("bp_next", 64'({in0, ipc0}), {16'd0, 32'h0C320000, 16'h0011});
        step(); #2;
        check("bp_last", 64'({in0, ipc0}), {16'd0, 32'hBD547E00, 16'h0012});

        step(); rst0 = 1; lat = 3;
        step(); rst0 = 0; #2;
        check("rd_req0", 64'({req0, addr0}), 64'h1_0010);
        step(); #2;
        check("rd_wait1", 64'(req0), 64'd0);
        step(); #2;
        check("rd_wait2", 64'({req0, val0}), 64'd0);
        step(); #2;
        check("rd_ack_issue", 64'({req0, addr0}), 64'h1_0011);
        step(); redirect = 1; redirect_pc = 16'h0200; #2;
        check("rd_pop_head", 64'({val0, ipc0}), 64'h1_0010);
        check("rd_no_req", 64'(req0), 64'd0);
        step(); redirect = 0; #2;
        check("rd_flushed", 64'({req0, val0}), 64'd0);
        step(); #2;
        check("rd_drain_ack", 64'({req0, val0}), 64'd0);
        step(); lat = 1; #2;
        check("rd_target_req", 64'({req0, addr0}), 64'h1_0200);
        check("rd_target_val", 64'(val0), 64'd0);
        step(); #2;
        check("rd_wait_val", 64'(val0), 64'd0);
        check("rd_next_req", 64'({req0, addr0}), 64'h1_0201);

        step(); redirect = 1; redirect_pc = 16'h0300; #2;
        check("ra_head", 64'({val0, in0, ipc0}), {15'd0, 1'b1, wordof(16'h0200), 16'h0200});
        check("ra_no_req", 64'(req0), 64'd0);
        step(); redirect = 0; #2;
        check("ra_target_req", 64'({req0, addr0}), 64'h1_0300);
        check("ra_flushed", 64'(val0), 64'd0);
        step(); #2;
        check("ra_next_req", 64'({req0, addr0}), 64'h1_0301);
        step(); #2;
        check("ra_head2", 64'({val0, ipc0}), 64'h1_0300);

        step(); rst0 = 1; sel = 1;
        step(); rst1 = 0; #2;
        check("wr_first", 64'({req1, addr1}), 64'h1_FFFF);
        step(); #2;
        check("wr_wrap", 64'({req1, addr1}), 64'h1_0000);
        step(); #2;
        check("wr_head", 64'({val1, ipc1}), 64'h1_FFFF);
        check("wr_next", 64'({req1, addr1}), 64'h1_0001);
        rst1 = 1; #1;
        check("mr_req_gated", 64'(req1), 64'd0);
        step(); rst1 = 0; #2;
        check("mr_outs", 64'({val1, in1, ipc1}), 64'd0);
        check("mr_restart", 64'({req1, addr1}), 64'h1_FFFF);
        step(); #2;
        check("mr_wrap", 64'({req1, addr1}), 64'h1_0000);
        step(); #2;
        check("mr_head", 64'({val1, in1, ipc1}), {15'd0, 1'b1, wordof(16'hFFFF), 16'hFFFF});
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 32-bit processor, directly upstream of the instruction decode controller. It owns the program counter and issues one-at-a-time read requests to instruction memory. Returned 32-bit words go into a small prefetch FIFO, and each word is presented to the controller's `in32` input with a valid/ready handshake. It also handles redirects (branch/jump) by flushing queued and in-flight instructions.

## Interface
Parameters:
- `ADDR_W`, default 16: PC / instruction-memory word-address width.
- `RESET_PC`, default 0: PC value loaded on reset.
- `DEPTH`, default 2: prefetch FIFO entries. Must be ≥ 2.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: one-cycle read request pulse.
- `imem_addr`  out  ADDR_W: word address. Valid when `imem_req`=1.
- `imem_ack`  in  1: one-cycle response pulse. Arrives ≥1 cycle after its `imem_req`. Exactly one ack per req.
- `imem_rdata`  in  32: instruction word. Valid when `imem_ack`=1.
- `redirect`  in  1: load a new PC and flush the pipeline.
- `redirect_pc`  in  ADDR_W: target address. Sampled when `redirect`=1.
- `in32`  out  32: instruction word to the controller (FIFO head).
- `in32_pc`  out  ADDR_W: address of `in32`.
- `in32_valid`  out  1: FIFO head is valid.
- `dec_ready`  in  1: controller accepts the head this cycle.

## Operation
FSM states:
- RUN: no request outstanding.
- WAIT: one request outstanding; its data will be kept.
- DRAIN: one request outstanding; its data will be discarded after a redirect.

Signals:
- `pop` = `in32_valid & dec_ready`.
- `push` = `imem_ack` in WAIT and no `redirect` this cycle.
- `space` = (`count + push − pop`) < `DEPTH`.
- `issue` = !`rst` & !`redirect` & `space` & (state==RUN | (state==WAIT & `imem_ack`)).
- `imem_req` = `issue` (combinational). `imem_addr` = `pc`.

Transitions and actions:
- On `issue`: `pc` ← `pc`+1, modulo 2^ADDR_W; the PC wraps from all-ones to 0. Next state is WAIT.
- WAIT with `imem_ack` and no issue: go to RUN.
- `redirect` (priority below `rst`, above everything else):
  - FIFO cleared, `pc` ← `redirect_pc`.
  - A concurrent `pop` is still a legal handshake; the word is consumed by the controller.
  - From WAIT without an ack this cycle: go to DRAIN.
  - From WAIT with an ack this cycle: ack data dropped, go to RUN.
  - From RUN: stay in RUN.
  - From DRAIN: `pc` updated to the new target; stay in DRAIN unless an ack arrives this cycle, then go to RUN.
- DRAIN with `imem_ack`: data discarded, go to RUN. No issue in that same cycle.
- `imem_ack` in RUN is ignored.
- Invariant: `count` + outstanding ≤ `DEPTH`. A push never hits a full FIFO. The bench asserts this invariant.
- FIFO entries hold {word, pc}. The head drives `in32` / `in32_pc` / `in32_valid`.
- `in32` and `in32_pc` are held stable while `in32_valid` & !`dec_ready`.
- Push and pop may occur in the same cycle.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `in32`=0, `in32_pc`=0, `in32_valid`=0. `pc`=`RESET_PC`, state RUN, `count`=0.
- First cycle with `rst`=0: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Ack latency: an ack in cycle t makes the word visible (`in32_valid`=1) in cycle t+1.
- Throughput: with 1-cycle memory latency and `dec_ready`=1, requests issue back-to-back and the controller receives one instruction per cycle.
- Redirect: `in32_valid`=0 in the cycle after `redirect`.
  - From RUN, or WAIT with a same-cycle ack: the first request to `redirect_pc` issues the cycle after `redirect`.
  - From DRAIN: the first request issues the cycle after the draining ack.
- Reset mid-operation: all state returns to reset values on the next edge and the outstanding request is forgotten. Instruction memory shares `rst`, so no stale ack can follow.
- Only `imem_req` depends combinationally on inputs (`imem_ack`, `dec_ready`, `redirect`). All other outputs are registered.

## Test plan
- Reset: `RESET_PC`=0x0010, hold `rst` 3 cycles → all outputs at reset values. First cycle after release: `imem_req`=1, `imem_addr`=0x0010.
- Streaming: 1-cycle ack returning 0x0C030A00, 0x0C320000, 0xBD547E00; `dec_ready`=1 → `in32` carries those words in order on consecutive cycles with `in32_pc` 0x10, 0x11, 0x12. No gaps.
- Backpressure: `dec_ready`=0 → exactly `DEPTH` words fetched, then `imem_req` stays 0 and `in32`=0x0C030A00 holds. Set `dec_ready`=1 → remaining words delivered with no loss or duplication.
- Redirect with in-flight request, ack delayed 3 cycles: `redirect_pc`=0x0200 → late ack data is not delivered. Next `imem_req` has addr 0x0200 the cycle after that ack. `in32_valid` stays 0 until the 0x0200 word arrives.
- Redirect in the same cycle as ack and pop: popped word is accepted, ack word dropped. Next cycle `imem_req`=1 with addr = `redirect_pc`.
- PC wrap and mid-stream reset: start at `RESET_PC`=0xFFFF → addresses go 0xFFFF, 0x0000. Assert `rst` during WAIT → outputs at reset values next cycle. Fetch restarts at 0xFFFF.
